// File: rtl/dht11_responder.sv
// Purpose: sensor-side DHT11 model; detects a host start pulse, then plays the response and 40-bit frame open-drain.
// Latency: busy rises 3 cycles after line_in rises at the end of a valid start; frame lasts 2240 cycles + sum of bit highs.
// Backpressure: none; phase timing is free-running and line_s is ignored once the frame starts.
//
// Ports:
//   clk, rst          1 MHz clock, asynchronous active-high reset
//   line_in           raw (asynchronous) level of the shared data line
//   humid_int/dec,
//   temp_int/dec      payload bytes, captured once when the host releases the line
//   corrupt_chk       (only with DHT11_RESPONDER_CHKSUM_ERR_EN) flips checksum bit 0 at capture
//   drive_low         1 = pull the line low, 0 = release to pull-up
//   busy              high from start acceptance until the frame ends
//   done              one-cycle pulse as the frame completes
// Optional feature macro: DHT11_RESPONDER_CHKSUM_ERR_EN
module dht11_responder #(
    parameter int START_MIN  = 16000,
    parameter int RESP_DELAY = 30,
    parameter int RESP_LOW   = 80,
    parameter int RESP_HIGH  = 80,
    parameter int BIT_LOW    = 50,
    parameter int ZERO_HIGH  = 26,
    parameter int ONE_HIGH   = 70,
    parameter int END_LOW    = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line_in,
    input  logic [7:0] humid_int,
    input  logic [7:0] humid_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
`ifdef DHT11_RESPONDER_CHKSUM_ERR_EN
    input  logic       corrupt_chk,
`endif
    output logic       drive_low,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE, ARMED, DELAY, R_LOW, R_HIGH, B_LOW, B_HIGH, E_LOW
    } state_t;

    state_t      state;
    logic [1:0]  sync;
    logic        line_s;
    logic [14:0] cnt;
    logic [5:0]  bit_idx;
    logic [39:0] shreg;
    logic [7:0]  chk;
    logic [14:0] phase_last;
    logic        phase_end;

    // Synchronizer resets to the released (high) level so reset never looks like a start pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], line_in};
        end
    end
    assign line_s = sync[1];

`ifdef DHT11_RESPONDER_CHKSUM_ERR_EN
    assign chk = (humid_int + humid_dec + temp_int + temp_dec) ^ {7'd0, corrupt_chk};
`else
    assign chk = humid_int + humid_dec + temp_int + temp_dec;
`endif

    // Last count value of the current phase; B_HIGH length follows the bit being sent.
    always_comb begin
        phase_last = '0;
        case (state)
            DELAY:   phase_last = 15'(RESP_DELAY - 1);
            R_LOW:   phase_last = 15'(RESP_LOW - 1);
            R_HIGH:  phase_last = 15'(RESP_HIGH - 1);
            B_LOW:   phase_last = 15'(BIT_LOW - 1);
            B_HIGH:  phase_last = shreg[39] ? 15'(ONE_HIGH - 1) : 15'(ZERO_HIGH - 1);
            E_LOW:   phase_last = 15'(END_LOW - 1);
            default: phase_last = '0;
        endcase
    end
    assign phase_end = (cnt == phase_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            drive_low <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!line_s) begin
                        cnt <= cnt + 15'd1;
                        if (cnt == 15'(START_MIN - 1)) begin
                            state <= ARMED;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                ARMED: begin
                    if (line_s) begin
                        shreg   <= {humid_int, humid_dec, temp_int, temp_dec, chk};
                        cnt     <= '0;
                        bit_idx <= '0;
                        busy    <= 1'b1;
                        state   <= DELAY;
                    end
                end
                DELAY: begin
                    cnt <= phase_end ? 15'd0 : cnt + 15'd1;
                    if (phase_end) begin
                        state     <= R_LOW;
                        drive_low <= 1'b1;
                    end
                end
                R_LOW: begin
                    cnt <= phase_end ? 15'd0 : cnt + 15'd1;
                    if (phase_end) begin
                        state     <= R_HIGH;
                        drive_low <= 1'b0;
                    end
                end
                R_HIGH: begin
                    cnt <= phase_end ? 15'd0 : cnt + 15'd1;
                    if (phase_end) begin
                        state     <= B_LOW;
                        drive_low <= 1'b1;
                    end
                end
                B_LOW: begin
                    cnt <= phase_end ? 15'd0 : cnt + 15'd1;
                    if (phase_end) begin
                        state     <= B_HIGH;
                        drive_low <= 1'b0;
                    end
                end
                B_HIGH: begin
                    cnt <= phase_end ? 15'd0 : cnt + 15'd1;
                    if (phase_end) begin
                        shreg     <= {shreg[38:0], 1'b0};
                        bit_idx   <= bit_idx + 6'd1;
                        drive_low <= 1'b1;
                        state     <= (bit_idx == 6'd39) ? E_LOW : B_LOW;
                    end
                end
                E_LOW: begin
                    cnt <= phase_end ? 15'd0 : cnt + 15'd1;
                    if (phase_end) begin
                        state     <= IDLE;
                        drive_low <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    bit_idx   <= '0;
                    drive_low <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_responder.sv
// Purpose: self-checking bench for dht11_responder; bus waveform is decoded and scored against queued expected frames.
// Latency: checks 3-cycle start recognition and exact phase lengths.
// Backpressure: n/a (bench only).
`timescale 1ns/1ps
module tb_dht11_responder;

    localparam int START_MIN = 16000;

    logic       clk = 1'b0;
    logic       rst;
    logic       line_in;
    logic [7:0] humid_int, humid_dec, temp_int, temp_dec;
`ifdef DHT11_RESPONDER_CHKSUM_ERR_EN
    logic       corrupt_chk;
`endif
    logic       drive_low, busy, done;

    int n_cmp = 0;
    int n_err = 0;
    logic [39:0] sb_q[$];

    always #5 clk = ~clk;

    dht11_responder dut (
        .clk        (clk),
        .rst        (rst),
        .line_in    (line_in),
        .humid_int  (humid_int),
        .humid_dec  (humid_dec),
        .temp_int   (temp_int),
        .temp_dec   (temp_dec),
`ifdef DHT11_RESPONDER_CHKSUM_ERR_EN
        .corrupt_chk(corrupt_chk),
`endif
        .drive_low  (drive_low),
        .busy       (busy),
        .done       (done)
    );

    // Reference frame: four bytes then their 8-bit truncated sum, optionally with bit 0 flipped.
    function automatic logic [39:0] ref_frame(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c, input logic [7:0] d,
                                              input logic flip);
        logic [8:0] s;
        logic [7:0] k;
        s = 9'(a) + 9'(b);
        s = 9'(s[7:0]) + 9'(c);
        s = 9'(s[7:0]) + 9'(d);
        k = s[7:0];
        if (flip) k[0] = ~k[0];
        return {a, b, c, d, k};
    endfunction

    task automatic load_bytes(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d, input logic flip);
        humid_int = a; humid_dec = b; temp_int = c; temp_dec = d;
`ifdef DHT11_RESPONDER_CHKSUM_ERR_EN
        corrupt_chk = flip;
`endif
        sb_q.push_back(ref_frame(a, b, c, d, flip));
    endtask

    // Host start: line low for n_low sampled cycles, release, count posedges until busy.
    task automatic host_start(input int n_low, output int lat);
        @(posedge clk); #1 line_in = 1'b0;
        repeat (n_low) @(posedge clk);
        #1 line_in = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); lat++; #1;
        end while (busy !== 1'b1 && lat < 20);
    endtask

    // Records drive_low every cycle busy is high, then decodes phases and bits.
    task automatic receive_frame(input string name);
        bit          tr[$];
        int          runs[$];
        int          n, cur, hsum, bad_low, want;
        logic [39:0] got, exp;
        @(negedge clk);
        n = 0;
        while (busy === 1'b1 && n < 6000) begin
            tr.push_back(drive_low);
            n++;
            @(negedge clk);
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++; $display("FAIL %s done_at_busy_fall: got %b want 1 (cycles %0d)", name, done, n);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++; $display("FAIL %s done_width: got %b want 0", name, done);
        end
        if (sb_q.size() == 0) begin
            n_err++; $display("FAIL %s scoreboard_empty: got 0 want 1 entry", name);
            return;
        end
        exp = sb_q.pop_front();
        n_cmp++;
        if (tr.size() == 0 || tr[0] !== 1'b0) begin
            n_err++; $display("FAIL %s first_level: got size %0d want released first", name, tr.size());
            return;
        end
        cur = 1;
        for (int i = 1; i < tr.size(); i++) begin
            if (tr[i] == tr[i-1]) cur++;
            else begin runs.push_back(cur); cur = 1; end
        end
        runs.push_back(cur);
        n_cmp++;
        if (runs.size() != 84) begin
            n_err++; $display("FAIL %s phase_count: got %0d want 84", name, runs.size());
            return;
        end
        n_cmp++;
        if (runs[0] != 30) begin n_err++; $display("FAIL %s resp_delay: got %0d want 30", name, runs[0]); end
        n_cmp++;
        if (runs[1] != 80) begin n_err++; $display("FAIL %s resp_low: got %0d want 80", name, runs[1]); end
        n_cmp++;
        if (runs[2] != 80) begin n_err++; $display("FAIL %s resp_high: got %0d want 80", name, runs[2]); end
        n_cmp++;
        if (runs[83] != 50) begin n_err++; $display("FAIL %s end_low: got %0d want 50", name, runs[83]); end
        bad_low = 0;
        hsum = 0;
        got = '0;
        for (int i = 0; i < 40; i++) begin
            if (runs[3 + 2*i] != 50) bad_low++;
            want = exp[39 - i] ? 70 : 26;
            hsum += want;
            got[39 - i] = (runs[4 + 2*i] > 48);
            n_cmp++;
            if (runs[4 + 2*i] != want) begin
                n_err++; $display("FAIL %s bit%0d_high: got %0d want %0d", name, i, runs[4 + 2*i], want);
            end
        end
        n_cmp++;
        if (bad_low != 0) begin n_err++; $display("FAIL %s bit_low: got %0d wrong want 0", name, bad_low); end
        n_cmp++;
        if (tr.size() != 2240 + hsum) begin
            n_err++; $display("FAIL %s busy_len: got %0d want %0d", name, tr.size(), 2240 + hsum);
        end
        n_cmp++;
        if (got !== exp) begin
            n_err++; $display("FAIL %s frame: got %h want %h", name, got, exp);
        end
        n_cmp++;
        if (got[7:0] !== exp[7:0]) begin
            n_err++; $display("FAIL %s checksum: got %h want %h", name, got[7:0], exp[7:0]);
        end
    endtask

    task automatic check_lat(input string name, input int lat);
        n_cmp++;
        if (lat != 3) begin n_err++; $display("FAIL %s start_latency: got %0d want 3", name, lat); end
    endtask

    task automatic test_reset;
        rst = 1'b1; line_in = 1'b1;
        humid_int = '0; humid_dec = '0; temp_int = '0; temp_dec = '0;
`ifdef DHT11_RESPONDER_CHKSUM_ERR_EN
        corrupt_chk = 1'b0;
`endif
        repeat (3) @(negedge clk);
        n_cmp++;
        if (drive_low !== 1'b0) begin n_err++; $display("FAIL reset drive_low: got %b want 0", drive_low); end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b want 0", done); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_nominal;
        int lat;
        load_bytes(8'h35, 8'h00, 8'h18, 8'h00, 1'b0);
        host_start(18001, lat);
        check_lat("nominal", lat);
        receive_frame("nominal");
    endtask

    task automatic test_short_pulse;
        logic seen;
        seen = 1'b0;
        @(posedge clk); #1 line_in = 1'b0;
        repeat (1000) begin @(negedge clk); seen = seen | busy | drive_low; end
        line_in = 1'b1;
        repeat (50) begin @(negedge clk); seen = seen | busy | drive_low; end
        n_cmp++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL short_pulse activity: got %b want 0", seen); end
    endtask

    task automatic test_wrap_and_change;
        int lat;
        load_bytes(8'hFF, 8'hFF, 8'h01, 8'h02, 1'b0);
        host_start(START_MIN + 10, lat);
        check_lat("wrap", lat);
        humid_int = 8'h00; humid_dec = 8'h5A; temp_int = 8'hC3; temp_dec = 8'h7E;
        receive_frame("wrap_change");
    endtask

    task automatic test_reset_midframe;
        int lat;
        humid_int = 8'h12; humid_dec = 8'h34; temp_int = 8'h56; temp_dec = 8'h78;
        host_start(START_MIN + 10, lat);
        check_lat("abort", lat);
        repeat (200) @(negedge clk);
        n_cmp++;
        if (drive_low !== 1'b1) begin n_err++; $display("FAIL abort in_bit_low: got %b want 1", drive_low); end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (drive_low !== 1'b0) begin n_err++; $display("FAIL abort async_drive_low: got %b want 0", drive_low); end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL abort async_busy: got %b want 0", busy); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        // Recovery frame with the shortest accepted start pulse.
`ifdef DHT11_RESPONDER_CHKSUM_ERR_EN
        load_bytes(8'h35, 8'h00, 8'h18, 8'h00, 1'b1);
`else
        load_bytes(8'hA5, 8'h5A, 8'h3C, 8'hC3, 1'b0);
`endif
        host_start(START_MIN, lat);
        check_lat("recover", lat);
        receive_frame("recover");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short_pulse();
        test_wrap_and_change();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
